// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared state type, constants and steering mix helper for the PWM mixer
package servo_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAILSAFE
    } pwm_state_t;

    localparam int SERVO_CENTER = 128;
    localparam int CODE_MAX     = 255;

    // sign = 0 gives the left code (speed + d), sign = 1 the right code (speed - d)
    function automatic logic [7:0] mix_clamp(
        input logic [7:0] speed,
        input logic [7:0] servo,
        input logic       sign
    );
        logic signed [9:0] d;
        logic signed [9:0] s;
        d = $signed({2'b00, servo}) - $signed(10'(SERVO_CENTER));
        s = sign ? $signed({2'b00, speed}) - d : $signed({2'b00, speed}) + d;
        return (s < 10'sd0) ? 8'd0 : (s > $signed(10'(CODE_MAX))) ? 8'(CODE_MAX) : s[7:0];
    endfunction

endpackage

// File: rtl/servo_pwm_mixer_ch.sv
// pwm_compare_ch: one PWM channel holding its active duty code and comparing it against the shared counter
module pwm_compare_ch
    import servo_pwm_pkg::*;
#(
    parameter int CW   = 21,
    parameter int STEP = 7812
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          load,
    input  logic [7:0]    code,
    input  logic [CW-1:0] cnt,
    output logic          pwm
);

    logic [7:0]    act_q;
    logic [7:0]    act_d;
    logic          pwm_q;
    logic          pwm_d;
    logic [CW-1:0] thr;

    // Leaving RUN wipes the active code, so a restart never replays a stale duty
    always_comb begin
        act_d = load ? code : (run ? act_q : 8'd0);
        thr   = CW'(act_q) * CW'(STEP);
        pwm_d = run && (cnt < thr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q <= 8'd0;
            pwm_q <= 1'b0;
        end else begin
            act_q <= act_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_mixer.sv
// servo_pwm_mixer: differential two-channel PWM with boundary-aligned duty updates, idle and timeout failsafe
module servo_pwm_mixer
    import servo_pwm_pkg::*;
#(
    parameter int PERIOD          = 2_000_000,
    parameter int TIMEOUT_PERIODS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] servo,
    input  logic [7:0] speed,
    output logic       PWM_L,
    output logic       PWM_R,
    output logic       failsafe
);

    localparam int STEP = PERIOD / 256;
    localparam int CW   = $clog2(PERIOD);
    localparam int TW   = $clog2(TIMEOUT_PERIODS + 1);

    pwm_state_t    state_q;
    pwm_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic          pend_q;
    logic          pend_d;
    logic [7:0]    pend_l_q;
    logic [7:0]    pend_l_d;
    logic [7:0]    pend_r_q;
    logic [7:0]    pend_r_d;
    logic          fs_q;
    logic          fs_d;
    logic          accept;
    logic          boundary;
    logic          load;
    logic          run;

    // A command accepted on the boundary cycle itself waits for the next boundary
    always_comb begin
        accept   = cmd_valid && !pend_q;
        boundary = (state_q != IDLE) && (cnt_q == CW'(PERIOD - 1));
        load     = boundary && pend_q && enable;
        run      = (state_q == RUN) && enable;
        pend_d   = accept || (pend_q && !load);
        pend_l_d = accept ? mix_clamp(speed, servo, 1'b0) : pend_l_q;
        pend_r_d = accept ? mix_clamp(speed, servo, 1'b1) : pend_r_q;
        cnt_d    = (!enable || state_q == IDLE || boundary) ? '0 : cnt_q + 1'b1;
        tmo_d    = (accept || !enable || state_q == IDLE) ? '0 :
                   (boundary && state_q == RUN && tmo_q != TW'(TIMEOUT_PERIODS)) ? tmo_q + 1'b1 : tmo_q;
        state_d  = !enable ? IDLE :
                   (state_q == IDLE || load) ? RUN :
                   (state_q == RUN && tmo_d == TW'(TIMEOUT_PERIODS)) ? FAILSAFE : state_q;
        fs_d     = (state_q == FAILSAFE) && enable;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            pend_q   <= 1'b0;
            pend_l_q <= 8'd0;
            pend_r_q <= 8'd0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            pend_q   <= pend_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            fs_q     <= fs_d;
        end
    end

    pwm_compare_ch #(.CW(CW), .STEP(STEP)) u_ch_l (
        .clk (clk),
        .rst (rst),
        .run (run),
        .load(load),
        .code(pend_l_q),
        .cnt (cnt_q),
        .pwm (PWM_L)
    );

    pwm_compare_ch #(.CW(CW), .STEP(STEP)) u_ch_r (
        .clk (clk),
        .rst (rst),
        .run (run),
        .load(load),
        .code(pend_r_q),
        .cnt (cnt_q),
        .pwm (PWM_R)
    );

    assign cmd_ready = !pend_q;
    assign failsafe  = fs_q;

endmodule

// File: tb/tb_servo_pwm_mixer.sv
// tb_servo_pwm_mixer: randomized scoreboard bench with a period-level reference model of the mixer
module tb_servo_pwm_mixer;

    localparam int P    = 512;
    localparam int T    = 3;
    localparam int STEP = P / 256;
    localparam int NPER = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] servo = 8'd0;
    logic [7:0] speed = 8'd0;
    logic       cmd_ready;
    logic       PWM_L;
    logic       PWM_R;
    logic       failsafe;

    servo_pwm_mixer #(.PERIOD(P), .TIMEOUT_PERIODS(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .servo    (servo),
        .speed    (speed),
        .PWM_L    (PWM_L),
        .PWM_R    (PWM_R),
        .failsafe (failsafe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hl;
        int hr;
        int fs;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_go = 1'b0;
    bit   mon_done = 1'b0;

    // Period-level model: pending slot, active codes, failsafe flag, boundaries since last accept
    bit m_pend = 1'b0;
    bit m_fs = 1'b0;
    int m_pl = 0, m_pr = 0, m_al = 0, m_ar = 0, m_tmo = 0;

    int         offs[NPER];
    bit         holds[NPER];
    logic [7:0] svs[NPER];
    logic [7:0] sps[NPER];

    function automatic int clampi(int v);
        return v < 0 ? 0 : (v > 255 ? 255 : v);
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(logic [7:0] sv, logic [7:0] sp, int o);
        int s = sv;
        int v = sp;
        check("cmd_ready", cmd_ready, !m_pend);
        if (!m_pend) begin
            m_pend = 1'b1;
            m_pl   = clampi(v + (s - 128));
            m_pr   = clampi(v - (s - 128));
            m_tmo  = 0;
        end
    endtask

    task automatic run_period(int off, bit hold, logic [7:0] sv, logic [7:0] sp);
        bit acc_b = 1'b0;
        bit was;
        sbq.push_back(exp_t'{hl: m_al * STEP, hr: m_ar * STEP, fs: int'(m_fs)});
        for (int o = 0; o < P; o++) begin
            @(negedge clk);
            mon_go    = 1'b1;
            cmd_valid = hold || (o == off);
            servo     = sv;
            speed     = sp;
            if (cmd_valid) begin
                was = m_pend;
                offer(sv, sp, o);
                if (!was && o == P - 1) acc_b = 1'b1;
            end
            @(posedge clk);
        end
        if (!acc_b && !m_fs) m_tmo = (m_tmo + 1 > T) ? T : m_tmo + 1;
        if (m_pend && !acc_b) begin
            m_al   = m_pl;
            m_ar   = m_pr;
            m_pend = 1'b0;
            m_fs   = 1'b0;
        end else if (!m_fs && m_tmo == T) begin
            m_fs = 1'b1;
            m_al = 0;
            m_ar = 0;
        end
    endtask

    initial begin : monitor
        int hl, hr, fs0;
        exp_t e;
        wait (mon_go);
        for (int w = 0; w < NPER; w++) begin
            hl = 0;
            hr = 0;
            fs0 = 0;
            for (int i = 0; i < P; i++) begin
                @(negedge clk);
                if (i == 0) fs0 = int'(failsafe);
                hl += int'(PWM_L);
                hr += int'(PWM_R);
            end
            if (sbq.size() == 0) check("scoreboard_empty", 0, 1);
            else begin
                e = sbq.pop_front();
                check($sformatf("hi_L_p%0d", w), hl, e.hl);
                check($sformatf("hi_R_p%0d", w), hr, e.hr);
                check($sformatf("failsafe_p%0d", w), fs0, e.fs);
            end
        end
        mon_done = 1'b1;
    end

    initial begin : stim
        int k, hl, hr, nr;
        offs[0] = 100;  svs[0] = 8'd128; sps[0] = 8'd100;
        offs[1] = 50;   svs[1] = 8'd178; sps[1] = 8'd100;
        offs[2] = 10;   svs[2] = 8'd0;   sps[2] = 8'd200;
        offs[3] = P - 1; svs[3] = 8'd128; sps[3] = 8'd40;
        offs[4] = -1;   svs[4] = 8'd200; sps[4] = 8'd200; holds[4] = 1'b1;
        for (int i = 5; i < 8; i++) begin offs[i] = -1; svs[i] = 8'd0; sps[i] = 8'd0; end
        offs[8] = 200;  svs[8] = 8'($urandom_range(0, 255)); sps[8] = 8'($urandom_range(0, 255));
        for (int i = 9; i < 18; i++) begin
            offs[i]  = ($urandom_range(0, 3) == 0) ? -1 :
                       ($urandom_range(0, 4) == 0) ? P - 1 : int'($urandom_range(0, P - 1));
            holds[i] = ($urandom_range(0, 7) == 0);
            svs[i]   = 8'($urandom_range(0, 255));
            sps[i]   = 8'($urandom_range(0, 255));
        end
        for (int i = 18; i < 20; i++) begin offs[i] = -1; holds[i] = 1'b1; svs[i] = 8'd128; sps[i] = 8'd200; end

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm_L", PWM_L, 0);
        check("rst_pwm_R", PWM_R, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_failsafe", failsafe, 0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_pwm_L", PWM_L, 0);
        check("idle_ready", cmd_ready, 1);
        enable = 1'b1;
        @(posedge clk);
        for (int p = 0; p < NPER; p++) run_period(offs[p], holds[p], svs[p], sps[p]);

        // Reset with a command pending, in the middle of a high phase
        for (int o = 0; o < 10; o++) begin
            @(negedge clk);
            cmd_valid = 1'b1; servo = 8'd178; speed = 8'd20;
            offer(servo, speed, o);
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_pwm_L", PWM_L, int'(9 < m_al * STEP));
        check("pre_rst_pwm_R", PWM_R, int'(9 < m_ar * STEP));
        check("pre_rst_ready", cmd_ready, !m_pend);
        k = 0;
        while (!mon_done && k < 4 * P) begin @(negedge clk); k++; end
        check("monitor_done", mon_done, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pwm_L", PWM_L, 0);
        check("async_rst_pwm_R", PWM_R, 0);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_failsafe", failsafe, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hl = 0; hr = 0; nr = 0;
        for (int i = 0; i < 3 * P + 10; i++) begin
            @(negedge clk);
            hl += int'(PWM_L);
            hr += int'(PWM_R);
            nr += int'(!cmd_ready);
        end
        check("post_rst_hi_L", hl, 0);
        check("post_rst_hi_R", hr, 0);
        check("post_rst_not_ready", nr, 0);
        check("timeout_failsafe", failsafe, 1);

        // Recover from failsafe, then drop enable mid-high-phase
        cmd_valid = 1'b1; servo = 8'd178; speed = 8'd100;
        check("fs_accept_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ready_drop", cmd_ready, 0);
        k = 0;
        while (!PWM_L && k < 2 * P + 10) begin @(negedge clk); k++; end
        check("resume_pwm_L", PWM_L, 1);
        check("resume_failsafe", failsafe, 0);
        repeat (20) @(negedge clk);
        check("mid_high_L", PWM_L, 1);
        check("mid_high_R", PWM_R, 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis_pwm_L", PWM_L, 0);
        check("dis_pwm_R", PWM_R, 0);
        check("dis_cnt", int'(dut.cnt_q), 0);
        repeat (4) @(negedge clk);
        cmd_valid = 1'b1; servo = 8'd128; speed = 8'd60;
        check("idle_accept_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            hl = 0; hr = 0; nr = 0;
            for (int i = 0; i < P; i++) begin
                @(negedge clk);
                hl += int'(PWM_L);
                hr += int'(PWM_R);
                nr += int'(failsafe);
            end
            check($sformatf("reen_hi_L_w%0d", w), hl, w * 120);
            check($sformatf("reen_hi_R_w%0d", w), hr, w * 120);
            check($sformatf("reen_failsafe_w%0d", w), nr, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_pwm_mixer.md
# servo_pwm_mixer

Two-channel differential PWM generator for the line follower's left and right drive outputs. It takes an 8-bit steering command and an 8-bit base speed through a valid/ready handshake and mixes them into left and right duty codes. Duty changes are applied only at period boundaries, so no glitches occur mid-period. It adds an enable-controlled idle state and a command-timeout failsafe, and sits between the steering controller and the motor-driver pins.

## Interface
- `PERIOD`, 2_000_000: PWM period in clk cycles (20 ms at 100 MHz); must be ≥ 256.
- `TIMEOUT_PERIODS`, 10: number of consecutive period boundaries with no accepted command before failsafe; must be ≥ 1.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run request; low forces IDLE.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: command slot free.
- `servo`, in, 8: steering, offset binary; 128 = straight.
- `speed`, in, 8: base duty code, unsigned.
- `PWM_L`, out, 1: left PWM, registered.
- `PWM_R`, out, 1: right PWM, registered.
- `failsafe`, out, 1: high while in FAILSAFE.

## Operation
- Constant `STEP = PERIOD / 256` (integer division). Counter `cnt` runs 0..PERIOD-1, width `$clog2(PERIOD)`, and wraps to 0. The boundary cycle is `cnt == PERIOD-1`.
- Mixing, on accept, uses 10-bit signed arithmetic:
  - d = servo − 128
  - L = clamp(speed + d, 0, 255)
  - R = clamp(speed − d, 0, 255)
- The clamped codes are stored in a one-deep pending register together with a full flag.
- Handshake: `cmd_ready = !pending_full`. A command is accepted on a cycle with `cmd_valid && cmd_ready`. Inputs only need to be stable in the accept cycle.
- Boundary cycle: if the pending register is full, it moves to the active codes `act_L`/`act_R` and pending_full clears, so `cmd_ready` rises the next cycle. An accept in the boundary cycle itself is not bypassed; it is applied at the following boundary.
- Output rule: PWM_x <= (state == RUN) && (cnt < act_x * STEP). Code 0 gives a constant low output; code 255 gives a high time of 255·STEP cycles.
- States: IDLE, RUN, FAILSAFE.
  - IDLE: `cnt` held at 0, outputs low, active codes cleared to 0, commands still accepted.
  - IDLE → RUN when `enable` = 1; `cnt` counts from 0 starting the next cycle. A pending command loads at the first boundary.
  - RUN → FAILSAFE when the period-timeout counter reaches TIMEOUT_PERIODS. Outputs go low on the next cycle and the active codes are cleared.
  - FAILSAFE → RUN on the first boundary at which the pending register is full.
  - Any state → IDLE when `enable` = 0. This takes effect the next cycle: outputs low, `cnt` = 0. The pending register is kept.
- Timeout counter:
  - increments at each boundary in RUN;
  - clears on every accept and on entry to IDLE;
  - saturates at TIMEOUT_PERIODS.
- Reset values: `cnt`=0, state IDLE, PWM_L=PWM_R=0, `failsafe`=0, `cmd_ready`=1, pending empty, active codes 0, timeout counter 0.
- Reset asserted mid-period drops both outputs immediately (asynchronously) and discards any pending command.

## Timing
- PWM outputs are registered with 1 cycle of latency from the `cnt` value. High time is exactly act_x·STEP cycles; the period is exactly PERIOD cycles.
- Command latency: accept-to-effect is between 1 and PERIOD+1 cycles, always aligned to the first `cnt` = 0 after the boundary.
- `cmd_ready` deasserts the cycle after an accept.
- `failsafe` is registered: it rises in the same cycle the outputs are first forced low and falls when state returns to RUN.

## Structure
- Package `servo_pwm_pkg` holds:
  - the state enum `pwm_state_t` (IDLE, RUN, FAILSAFE);
  - the constants `SERVO_CENTER = 128` and `CODE_MAX = 255`;
  - the function `mix_clamp(speed, servo, sign)`, which returns the 8-bit code.
- Sub-module `pwm_compare_ch`: one per channel. It holds the active code register, loads it at the boundary, and produces the registered compare output from the shared `cnt`. The top level owns the counter, FSM, handshake, pending register and timeout.

## Test plan
All scenarios use PERIOD=512 (STEP=2) and TIMEOUT_PERIODS=3.
- Reset then `enable`=1, accept servo=128, speed=100 → from the second period, PWM_L and PWM_R are each high 200 cycles per 512-cycle period.
- Accept servo=178, speed=100 → L=150, R=50, giving 300 and 100 high cycles. Then accept servo=0, speed=200 → L=72, R=255, i.e. both clamp checks (d=−128 gives L=200−128=72 and R=328→255), giving 144 and 510 high cycles.
- Accept a command in the boundary cycle → it is not applied until the next boundary, and `cmd_ready` stays low through that next full period; a `cmd_valid` held during that period is not accepted.
- Stop commanding in RUN → after 3 boundaries, outputs go low and `failsafe` = 1. A new accept gives `failsafe` = 0 and the outputs resume at the next boundary with the new codes.
- `enable` dropped mid-high-phase → outputs are low next cycle and `cnt` = 0. Re-enabling gives no PWM until the first boundary loads a pending command.
- `rst` low mid-period with a command pending → all outputs 0 immediately, `cmd_ready` = 1, and nothing is applied after reset release.
